mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences instruction-fetch and data-access requests onto one shared single-port, fixed-latency memory, replacing the split instruction/data memories in the multi-cycle CPU.
- Grants one requester per transaction and holds the memory command stable for the whole access.
- Returns read data with a one-cycle done pulse.
- Data has priority; a starvation guard guarantees fetch progress.

Parameters:
LAT, 4, memory read latency in cycles (legal 1..15); mem_rdata valid at the LAT-th rising edge after the mem_en cycle
STARVE, 4, max consecutive data grants while if_req is pending before fetch is forced (legal 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request, level, held until if_done
if_addr  input  16  fetch address
if_rdata  output  16  fetched word, registered
if_done  output  1  one-cycle pulse, fetch complete
d_req  input  1  data request, level, held until d_done
d_wr  input  1  1 = store, 0 = load
d_addr  input  16  data address
d_wdata  input  16  store data
d_rdata  output  16  loaded word, registered
d_done  output  1  one-cycle pulse, data access complete
mem_en  output  1  memory command strobe, exactly one cycle per transaction
mem_wr  output  1  write qualifier, valid with mem_en
mem_addr  output  16  memory address, held for the whole transaction
mem_wdata  output  16  memory write data, held for the whole transaction
mem_rdata  input  16  memory read data
gnt_d  output  1  1 while the current or last transaction owner is data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, starve_cnt=0. All outputs are 0, including rdata registers. A transaction in flight is abandoned with no done pulse.
- States: IDLE, BUSY, RESP.
- IDLE: at a rising edge with any request high, latch owner, address, wdata and wr into mem_*. Then state←BUSY, cnt←LAT-1.
  - If no request is high, stay in IDLE; mem_* hold their last values and mem_en=0.
- Arbitration, evaluated at the IDLE edge:
  - d_req only → data.
  - if_req only → fetch.
  - Both high → data, unless starve_cnt==STARVE, then fetch.
- starve_cnt:
  - increments on a data grant while if_req=1;
  - clears on any fetch grant, or on any grant while if_req=0;
  - saturates at STARVE.
- BUSY:
  - mem_en=1 only in the first BUSY cycle; mem_wr=d_wr in that cycle for a data grant, 0 for fetch.
  - cnt decrements each edge.
  - At the edge where cnt==0: for a read, capture mem_rdata into the owner's rdata register. State←RESP.
- RESP, one cycle:
  - The owner's done=1.
  - Requests are ignored, so a held req is not re-accepted.
  - Next state is IDLE.
- Stores: d_rdata is unchanged; d_done still pulses after the full latency.
- rdata registers hold their value until the owner's next completed read.
- Latency: request accepted at edge E0 → done high in the cycle after edge E0+LAT.
  - Back-to-back occupancy is LAT+2 cycles per transaction.
- Requests arriving during BUSY/RESP wait; nothing is queued beyond the held level request.
- A requester dropping req mid-transaction does not abort the access; done still pulses.
- Only one done is high in any cycle; if_done and d_done are never simultaneous.
- gnt_d updates at each grant and holds between transactions.

Test Plan:
- Reset with LAT=4, then if_req=1, if_addr=0x0010, memory returns 0xA5A5 → mem_en is a single pulse with mem_addr=0x0010 and mem_wr=0; if_done pulses 5 cycles after the accept edge; if_rdata=0xA5A5.
- d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 → one mem_en with mem_wr=1 and mem_wdata=0x1234; d_done pulses after LAT; d_rdata retains its prior value.
- if_req and d_req high together, both held continuously with loads, STARVE=4 → grant order D,D,D,D,I,D…; no consecutive done pulses are closer than LAT+2 cycles.
- d_req held high through RESP → exactly one d_done per transaction; a new access starts only from IDLE, one cycle after done.
- rst_n pulled low in the second BUSY cycle → all outputs 0 immediately; no done pulse; a fresh request after release completes normally.
- LAT=1 → done in the second cycle after accept; data is captured correctly at the boundary latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared fixed-latency single-port memory
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   if_req, if_addr                 fetch request (level, held until if_done) and address
//   if_rdata, if_done               registered fetched word, one-cycle completion pulse
//   d_req, d_wr, d_addr, d_wdata    data request (level), store qualifier, address, store data
//   d_rdata, d_done                 registered loaded word, one-cycle completion pulse
//   mem_en, mem_wr                  one-cycle command strobe per transaction, write qualifier
//   mem_addr, mem_wdata             address and write data, held for the whole transaction
//   mem_rdata                       memory read data, valid LAT edges after the mem_en cycle
//   gnt_d                           owner of the current or most recent transaction is data
module mem_arbiter #(
    parameter int LAT    = 4,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        gnt_d
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT   = 4'(LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE);

    state_e      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [3:0]  starve_q,    starve_d;
    logic        gnt_d_q,     gnt_d_d;
    logic        mem_en_q,    mem_en_d;
    logic        mem_wr_q,    mem_wr_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] if_rdata_q,  if_rdata_d;
    logic [15:0] d_rdata_q,   d_rdata_d;

    // Data wins a collision unless fetch has already lost STARVE grants in a row.
    logic pick_fetch;
    always_comb begin
        pick_fetch = 1'b0;
        if (if_req && d_req) begin
            pick_fetch = (starve_q == STARVE_MAX);
        end else begin
            pick_fetch = if_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        gnt_d_d     = gnt_d_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d  = S_BUSY;
                    cnt_d    = CNT_INIT;
                    mem_en_d = 1'b1;
                    gnt_d_d  = !pick_fetch;
                    if (pick_fetch) begin
                        mem_addr_d = if_addr;
                        mem_wr_d   = 1'b0;
                    end else begin
                        mem_addr_d  = d_addr;
                        mem_wr_d    = d_wr;
                        mem_wdata_d = d_wdata;
                    end
                    // Only a data grant that leaves fetch waiting counts toward starvation.
                    if (!pick_fetch && if_req) begin
                        if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    if (!mem_wr_q) begin
                        if (gnt_d_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Requests are not looked at here; a held request is taken from IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            starve_q    <= 4'd0;
            gnt_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            if_rdata_q  <= 16'h0000;
            d_rdata_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            gnt_d_q     <= gnt_d_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_done   = (state_q == S_RESP) && !gnt_d_q;
    assign d_done    = (state_q == S_RESP) &&  gnt_d_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign gnt_d     = gnt_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (LAT=4 and LAT=1 instances)
module tb_mem_arbiter;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;
    localparam int ST0  = 4;
    localparam int ST1  = 2;

    logic             clk;
    logic [1:0]       rst_n, if_req, if_done, d_req, d_wr, d_done, mem_en, mem_wr, gnt_d;
    logic [1:0][15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0][15:0] mem_addr, mem_wdata, mem_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .LAT    (g == 0 ? LAT0 : LAT1),
            .STARVE (g == 0 ? ST0 : ST1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_done   (if_done[g]),
            .d_req     (d_req[g]),
            .d_wr      (d_wr[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_done    (d_done[g]),
            .mem_en    (mem_en[g]),
            .mem_wr    (mem_wr[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .gnt_d     (gnt_d[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int st_of(input int i);
        return (i == 0) ? ST0 : ST1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Memory environment: the word is only presented in the LAT-th cycle after mem_en.
    logic [15:0] env_mem [2][256];
    logic [15:0] ref_mem [2][256];
    int          age     [2];
    bit          act_m   [2];
    bit          env_wr  [2];
    logic [15:0] env_a   [2];

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                act_m[i] = 1'b0;
                age[i]   = 0;
            end else if (mem_en[i]) begin
                act_m[i]  = 1'b1;
                age[i]    = 1;
                env_wr[i] = mem_wr[i];
                env_a[i]  = mem_addr[i];
                if (mem_wr[i]) env_mem[i][mem_addr[i][7:0]] = mem_wdata[i];
            end else if (act_m[i]) begin
                age[i]++;
                if (age[i] > lat_of(i)) act_m[i] = 1'b0;
            end
            if (act_m[i] && !env_wr[i] && age[i] == lat_of(i))
                mem_rdata[i] = env_mem[i][env_a[i][7:0]];
            else
                mem_rdata[i] = 16'($urandom);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_flags"}, 32'({if_done[i], d_done[i], mem_en[i], mem_wr[i], gnt_d[i]}), 32'd0);
        chk({tag, "_rdata"}, 32'({if_rdata[i], d_rdata[i]}), 32'd0);
        chk({tag, "_mem"}, 32'({mem_addr[i], mem_wdata[i]}), 32'd0);
    endtask

    typedef struct {
        int          inst;
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          pre;
        logic [15:0] pre_val;
        logic [15:0] exp_if_rd;
        logic [15:0] exp_d_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input string tag);
        int  i;
        int  n_en;
        int  lat;
        i    = v.inst;
        n_en = 0;
        lat  = 0;
        if (v.pre) begin
            env_mem[i][v.addr[7:0]] = v.pre_val;
            ref_mem[i][v.addr[7:0]] = v.pre_val;
        end
        if (v.is_d) begin
            d_req[i] = 1'b1; d_wr[i] = v.wr; d_addr[i] = v.addr; d_wdata[i] = v.wdata;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = v.addr;
        end
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (mem_en[i]) begin
                n_en++;
                chk({tag, "_mem_addr"}, 32'(mem_addr[i]), 32'(v.addr));
                chk({tag, "_mem_wr"}, 32'(mem_wr[i]), 32'(v.is_d && v.wr));
                chk({tag, "_gnt_d"}, 32'(gnt_d[i]), 32'(v.is_d));
                if (v.is_d && v.wr) chk({tag, "_mem_wdata"}, 32'(mem_wdata[i]), 32'(v.wdata));
            end
            if (if_done[i] || d_done[i]) begin
                lat = k;
                chk({tag, "_done_sel"}, 32'({if_done[i], d_done[i]}), v.is_d ? 32'd1 : 32'd2);
                if_req[i] = 1'b0;
                d_req[i]  = 1'b0;
            end
        end
        if_req[i] = 1'b0;
        d_req[i]  = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_en_count"}, 32'(n_en), 32'd1);
        chk({tag, "_if_rdata"}, 32'(if_rdata[i]), 32'(v.exp_if_rd));
        chk({tag, "_d_rdata"}, 32'(d_rdata[i]), 32'(v.exp_d_rd));
        for (int k = 0; k < 2; k++) begin
            tick();
            chk({tag, "_quiet"}, 32'({mem_en[i], if_done[i], d_done[i]}), 32'd0);
        end
    endtask

    // Transaction-level reference model state for the random phase.
    int          m_starve [2];
    bit          m_out    [2];
    bit          m_seen   [2];
    int          m_done_at[2];
    int          m_last   [2];
    bit          m_own_d  [2];
    bit          m_wr     [2];
    logic [15:0] m_addr   [2];
    logic [15:0] m_exp    [2];
    logic [15:0] m_if_rd  [2];
    logic [15:0] m_d_rd   [2];
    bit          s_if [2], s_d [2], s_wr [2];
    logic [15:0] s_ia [2], s_da [2], s_wd [2];
    bit          bz_i [2], bz_d [2], acc_i [2], acc_d [2];
    bit          stop_new;

    task automatic model_step(input int i);
        bit exp_en;
        bit exp_done;
        exp_en = !m_out[i] && (m_last[i] < cyc - 1) && (s_if[i] || s_d[i]);
        chk("rnd_mem_en", 32'(mem_en[i]), 32'(exp_en));
        if (exp_en) begin
            m_own_d[i] = s_d[i] && !(s_if[i] && m_starve[i] == st_of(i));
            m_wr[i]    = m_own_d[i] ? s_wr[i] : 1'b0;
            m_addr[i]  = m_own_d[i] ? s_da[i] : s_ia[i];
            if (m_own_d[i] && s_if[i]) m_starve[i] = (m_starve[i] < st_of(i)) ? m_starve[i] + 1 : m_starve[i];
            else m_starve[i] = 0;
            m_out[i]     = 1'b1;
            m_seen[i]    = 1'b1;
            m_done_at[i] = cyc + lat_of(i);
            if (m_wr[i]) begin
                ref_mem[i][m_addr[i][7:0]] = s_wd[i];
                chk("rnd_mem_wdata", 32'(mem_wdata[i]), 32'(s_wd[i]));
            end else begin
                m_exp[i] = ref_mem[i][m_addr[i][7:0]];
            end
            chk("rnd_mem_wr", 32'(mem_wr[i]), 32'(m_wr[i]));
            if (m_own_d[i]) acc_d[i] = 1'b1;
            else acc_i[i] = 1'b1;
        end
        if (m_seen[i]) begin
            chk("rnd_mem_addr", 32'(mem_addr[i]), 32'(m_addr[i]));
            chk("rnd_gnt_d", 32'(gnt_d[i]), 32'(m_own_d[i]));
        end
        exp_done = m_out[i] && (cyc == m_done_at[i]);
        if (exp_done && !m_wr[i]) begin
            if (m_own_d[i]) m_d_rd[i] = m_exp[i];
            else m_if_rd[i] = m_exp[i];
        end
        chk("rnd_if_done", 32'(if_done[i]), 32'(exp_done && !m_own_d[i]));
        chk("rnd_d_done", 32'(d_done[i]), 32'(exp_done && m_own_d[i]));
        chk("rnd_if_rdata", 32'(if_rdata[i]), 32'(m_if_rd[i]));
        chk("rnd_d_rdata", 32'(d_rdata[i]), 32'(m_d_rd[i]));
        if (exp_done) begin
            m_out[i]  = 1'b0;
            m_last[i] = cyc;
        end
    endtask

    task automatic stim_step(input int i);
        if (if_done[i]) begin
            acc_i[i] = 1'b0;
            if (!stop_new && $urandom_range(0, 3) == 0) begin
                if_req[i] = 1'b1; if_addr[i] = 16'($urandom_range(0, 15));
            end else begin
                if_req[i] = 1'b0; bz_i[i] = 1'b0;
            end
        end else if (!bz_i[i]) begin
            if (!stop_new && $urandom_range(0, 2) == 0) begin
                if_req[i] = 1'b1; if_addr[i] = 16'($urandom_range(0, 15)); bz_i[i] = 1'b1;
            end
        end else if (acc_i[i] && $urandom_range(0, 15) == 0) begin
            if_req[i] = 1'b0;
        end
        if (d_done[i]) begin
            acc_d[i] = 1'b0;
            if (!stop_new && $urandom_range(0, 3) == 0) begin
                d_req[i] = 1'b1; d_addr[i] = 16'($urandom_range(0, 15));
                d_wr[i] = 1'($urandom); d_wdata[i] = 16'($urandom);
            end else begin
                d_req[i] = 1'b0; bz_d[i] = 1'b0;
            end
        end else if (!bz_d[i]) begin
            if (!stop_new && $urandom_range(0, 1) == 0) begin
                d_req[i] = 1'b1; d_addr[i] = 16'($urandom_range(0, 15));
                d_wr[i] = 1'($urandom); d_wdata[i] = 16'($urandom); bz_d[i] = 1'b1;
            end
        end else if (acc_d[i] && $urandom_range(0, 15) == 0) begin
            d_req[i] = 1'b0;
        end
        s_if[i] = if_req[i]; s_ia[i] = if_addr[i];
        s_d[i] = d_req[i]; s_da[i] = d_addr[i]; s_wr[i] = d_wr[i]; s_wd[i] = d_wdata[i];
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [5:0] order;
        int         n_done;
        int         last_done;
        vec_t       vr;

        rst_n = 2'b00; if_req = '0; d_req = '0; d_wr = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            act_m[i] = 1'b0; age[i] = 0;
            for (int a = 0; a < 256; a++) begin
                env_mem[i][a] = 16'($urandom); ref_mem[i][a] = env_mem[i][a];
            end
        end

        vecs[0] = '{0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 5};
        vecs[1] = '{0, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 16'h0000, 16'hA5A5, 16'h0000, 5};
        vecs[2] = '{0, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0000, 16'hA5A5, 16'h1234, 5};
        vecs[3] = '{0, 1'b1, 1'b0, 16'h0033, 16'h0000, 1'b1, 16'hBEEF, 16'hA5A5, 16'hBEEF, 5};
        vecs[4] = '{0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A, 16'hBEEF, 5};
        vecs[5] = '{1, 1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h1111, 16'h1111, 16'h0000, 2};
        vecs[6] = '{1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h2222, 16'h1111, 16'h2222, 2};
        vecs[7] = '{1, 1'b1, 1'b1, 16'h0003, 16'h9999, 1'b0, 16'h0000, 16'h1111, 16'h2222, 2};
        vecs[8] = '{1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 16'h1111, 16'h9999, 2};

        #1;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        tick();
        rst_n = 2'b11;

        for (int n = 0; n < 9; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

        // Both requesters held with loads: data four times, then a forced fetch.
        env_mem[0][8'h40] = 16'h4444;
        env_mem[0][8'h50] = 16'h5555;
        if_req[0] = 1'b1; if_addr[0] = 16'h0040;
        d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0050;
        order = '0; n_done = 0; last_done = 0;
        for (int k = 0; k < 80 && n_done < 6; k++) begin
            tick();
            if (if_done[0] || d_done[0]) begin
                chk("starve_one_done", 32'(if_done[0] && d_done[0]), 32'd0);
                if (n_done > 0) chk("starve_spacing", 32'(cyc - last_done), 32'(LAT0 + 2));
                if (d_done[0]) chk("starve_d_rdata", 32'(d_rdata[0]), 32'h5555);
                else chk("starve_if_rdata", 32'(if_rdata[0]), 32'h4444);
                order[n_done] = d_done[0];
                n_done++;
                last_done = cyc;
                if (n_done == 6) begin
                    if_req[0] = 1'b0; d_req[0] = 1'b0;
                end
            end
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("starve_count", 32'(n_done), 32'd6);
        chk("starve_order", 32'(order), 32'b101111);
        tick(); tick();

        // Reset in the second BUSY cycle abandons the access silently.
        env_mem[0][8'h60] = 16'h6666;
        d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0060;
        tick();
        tick();
        rst_n[0] = 1'b0;
        #1;
        chk_zero(0, "midreset");
        d_req[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midreset_quiet", 32'({if_done[0], d_done[0], mem_en[0]}), 32'd0);
        end
        rst_n[0] = 1'b1;
        vr = '{0, 1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h6666, 5};
        run_vec(vr, "post_reset");

        // Random phase from a fresh reset against the transaction-level model.
        rst_n = 2'b00;
        #1;
        chk_zero(0, "reset_rnd0");
        chk_zero(1, "reset_rnd1");
        tick();
        rst_n = 2'b11;
        stop_new = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) begin
                env_mem[i][a] = 16'($urandom); ref_mem[i][a] = env_mem[i][a];
            end
            m_starve[i] = 0; m_out[i] = 1'b0; m_seen[i] = 1'b0; m_last[i] = -100;
            m_if_rd[i] = 16'h0000; m_d_rd[i] = 16'h0000;
            bz_i[i] = 1'b0; bz_d[i] = 1'b0; acc_i[i] = 1'b0; acc_d[i] = 1'b0;
            s_if[i] = 1'b0; s_d[i] = 1'b0; s_wr[i] = 1'b0;
            s_ia[i] = '0; s_da[i] = '0; s_wd[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) model_step(i);
            for (int i = 0; i < 2; i++) stim_step(i);
        end
        stop_new = 1'b1;
        for (int c = 0; c < 300 && (bz_i[0] || bz_d[0] || bz_i[1] || bz_d[1]); c++) begin
            tick();
            for (int i = 0; i < 2; i++) model_step(i);
            for (int i = 0; i < 2; i++) stim_step(i);
        end
        chk("drain_idle", 32'({bz_i[0], bz_d[0], bz_i[1], bz_d[1]}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
